inst_cache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the program counter and instruction memory.

---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_data_ram.sv | 25 ++
 rtl/inst_cache.sv | 165 ++++++++++++++++
 tb/tb_inst_cache.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// Default build has no perf counters; define ICACHE_PERF_CNT_EN in inst_cache to add them.
package icache_pkg;

    typedef enum logic {
        IDLE,
        REFILL
    } icache_state_e;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_LINES  = 64;
    localparam int LINE_WORDS = 4;
    localparam int ADDR_WIDTH = 32;

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data storage: one word per (line, offset), synchronous write and asynchronous read.
module icache_data_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with single-line refill and flush (fence.i).
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module inst_cache
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    input  logic                  fetch_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic                  inst_valid,
    output logic                  inst_cache_stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    icache_state_e state, next_state;

    logic [NUM_LINES-1:0]  valid;
    logic [TAG_W-1:0]      tag_ram [NUM_LINES];
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [OFF_W-1:0]      word_cnt;
    logic                  pending_flush;

    logic [OFF_W-1:0]      pc_off;
    logic [IDX_W-1:0]      pc_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic [IDX_W-1:0]      fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  hit;
    logic                  start_refill;
    logic                  word_done;
    logic                  last_word;
    logic                  unused_pc_bits;

    assign pc_off    = pc_addr[OFF_W+1:2];
    assign pc_idx    = pc_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign pc_tag    = pc_addr[ADDR_WIDTH-1:IDX_W+OFF_W+2];
    assign fill_idx  = base_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign fill_tag  = base_addr[ADDR_WIDTH-1:IDX_W+OFF_W+2];
    assign line_base = {pc_addr[ADDR_WIDTH-1:OFF_W+2], {(OFF_W+2){1'b0}}};
    assign unused_pc_bits = ^pc_addr[1:0];

    assign hit = fetch_en && valid[pc_idx] && (tag_ram[pc_idx] == pc_tag)
                 && (state == IDLE) && !flush;

    // Memory words only count while a request is outstanding; stray rvalids are dropped.
    assign word_done = (state == REFILL) && mem_rvalid;
    assign last_word = word_done && (word_cnt == OFF_W'(LINE_WORDS - 1));

    always_comb begin
        next_state       = state;
        inst_out         = '0;
        inst_valid       = 1'b0;
        inst_cache_stall = 1'b0;
        mem_req          = 1'b0;
        mem_addr         = '0;
        start_refill     = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    inst_cache_stall = 1'b1;
                end else if (fetch_en) begin
                    if (hit) begin
                        inst_valid = 1'b1;
                        inst_out   = ram_rdata;
                    end else begin
                        inst_cache_stall = 1'b1;
                        start_refill     = 1'b1;
                        next_state       = REFILL;
                    end
                end
            end
            REFILL: begin
                mem_req          = 1'b1;
                inst_cache_stall = 1'b1;
                mem_addr         = base_addr + ADDR_WIDTH'({word_cnt, 2'b00});
                if (last_word) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A flush seen at any point of a refill leaves every line invalid once the refill ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            valid         <= '0;
            word_cnt      <= '0;
            pending_flush <= 1'b0;
            base_addr     <= '0;
        end else begin
            state <= next_state;
            if (start_refill) begin
                base_addr <= line_base;
                word_cnt  <= '0;
            end
            if (state == IDLE && flush) begin
                valid <= '0;
            end
            if (state == REFILL && flush) begin
                pending_flush <= 1'b1;
            end
            if (word_done) begin
                word_cnt <= word_cnt + OFF_W'(1);
            end
            if (last_word) begin
                if (pending_flush || flush) begin
                    valid <= '0;
                end else begin
                    valid[fill_idx] <= 1'b1;
                end
                pending_flush <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && last_word && !(pending_flush || flush)) begin
            tag_ram[fill_idx] <= fill_tag;
        end
    end

    icache_data_ram #(
        .DEPTH(NUM_LINES * LINE_WORDS),
        .AW   (IDX_W + OFF_W),
        .WIDTH(DATA_WIDTH)
    ) u_data_ram (
        .clk  (clk),
        .we   (word_done),
        .waddr({fill_idx, word_cnt}),
        .wdata(mem_rdata),
        .raddr({pc_idx, pc_off}),
        .rdata(ram_rdata)
    );

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (start_refill) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: stimulus queues expected hit words and refill addresses,
// a negedge monitor pops and compares them whenever the DUT presents a hit or a memory beat.
module tb_inst_cache;

    logic        clk;
    logic        reset;
    logic [31:0] pc_addr;
    logic        fetch_en;
    logic        flush;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        inst_cache_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_vectors;
    int n_miscompares;

    logic [31:0] exp_inst[$];
    logic [31:0] exp_addr[$];

    inst_cache dut (
        .clk             (clk),
        .reset           (reset),
        .pc_addr         (pc_addr),
        .fetch_en        (fetch_en),
        .flush           (flush),
        .inst_out        (inst_out),
        .inst_valid      (inst_valid),
        .inst_cache_stall(inst_cache_stall),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .mem_rvalid      (mem_rvalid)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory contents: word at byte address a holds 0xA0 + a/4.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + (a >> 2);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic fe, input logic fl,
                                 input logic rv, input logic [31:0] rd);
        pc_addr    = pc;
        fetch_en   = fe;
        flush      = fl;
        mem_rvalid = rv;
        mem_rdata  = rd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every hit must match the next queued word; every memory beat the next queued address.
    always @(negedge clk) begin
        if (inst_valid) begin
            n_vectors++;
            if (exp_inst.size() == 0) begin
                n_miscompares++;
                $display("[TB] FAIL unexpected_hit: got 0x%08h, expected no hit at %0t", inst_out, $time);
            end else begin
                logic [31:0] e;
                e = exp_inst.pop_front();
                if (inst_out !== e) begin
                    n_miscompares++;
                    $display("[TB] FAIL hit_data: got 0x%08h, expected 0x%08h at %0t", inst_out, e, $time);
                end
            end
        end else if (inst_out !== 32'h0) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL idle_inst_out: got 0x%08h, expected 0x00000000 at %0t", inst_out, $time);
        end
        if (mem_req && mem_rvalid) begin
            n_vectors++;
            if (exp_addr.size() == 0) begin
                n_miscompares++;
                $display("[TB] FAIL unexpected_beat: got addr 0x%08h, expected none at %0t", mem_addr, $time);
            end else begin
                logic [31:0] e;
                e = exp_addr.pop_front();
                if (mem_addr !== e) begin
                    n_miscompares++;
                    $display("[TB] FAIL refill_addr: got 0x%08h, expected 0x%08h at %0t", mem_addr, e, $time);
                end
            end
        end
    end

    task automatic fetchHit(input logic [31:0] pc, input logic [31:0] expected);
        exp_inst.push_back(expected);
        applyStimulus(pc, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("hit_stall", {31'b0, inst_cache_stall}, 32'd0);
        checkOutput("hit_mem_req", {31'b0, mem_req}, 32'd0);
        nextCycle();
    endtask

    // Miss cycle, then a full line refill with lat idle cycles before each word.
    task automatic doMiss(input logic [31:0] pc, input int lat, input int flush_at);
        logic [31:0] base;
        base = pc & ~32'hF;
        for (int i = 0; i < 4; i++) exp_addr.push_back(base + 32'(4 * i));
        applyStimulus(pc, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("miss_stall", {31'b0, inst_cache_stall}, 32'd1);
        checkOutput("miss_valid", {31'b0, inst_valid}, 32'd0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < lat; w++) begin
                applyStimulus(pc, 1'b1, 1'b0, 1'b0, 32'h0);
                @(negedge clk);
                checkOutput("refill_req", {31'b0, mem_req}, 32'd1);
                nextCycle();
            end
            applyStimulus(pc, 1'b1, (i == flush_at), 1'b1, mem_word(base + 32'(4 * i)));
            @(negedge clk);
            checkOutput("refill_stall", {31'b0, inst_cache_stall}, 32'd1);
            nextCycle();
        end
        applyStimulus(pc, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        reset         = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("reset_stall", {31'b0, inst_cache_stall}, 32'd0);
        checkOutput("reset_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        checkOutput("reset_valid", {31'b0, inst_valid}, 32'd0);
        nextCycle();
        reset = 1'b0;

        // Cold miss with single-cycle memory
        doMiss(32'h0, 0, -1);
        fetchHit(32'h4, 32'hA1);
        fetchHit(32'h0, 32'hA0);
        fetchHit(32'hC, 32'hA3);

        // Conflict on index 0
        doMiss(32'h400, 2, -1);
        fetchHit(32'h408, 32'h1A2);
        doMiss(32'h0, 1, -1);
        fetchHit(32'h8, 32'hA2);

        // Flush during refill of 0x20
        doMiss(32'h20, 0, 1);
        doMiss(32'h20, 0, -1);
        fetchHit(32'h24, 32'hA9);
        doMiss(32'h0, 0, -1);
        fetchHit(32'h0, 32'hA0);

        // Flush in IDLE coinciding with a would-be hit
        applyStimulus(32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("idle_flush_stall", {31'b0, inst_cache_stall}, 32'd1);
        checkOutput("idle_flush_req", {31'b0, mem_req}, 32'd0);
        nextCycle();
        doMiss(32'h0, 0, -1);
        fetchHit(32'h4, 32'hA1);

        // Reset after two of four refill words
        exp_addr.push_back(32'h40);
        exp_addr.push_back(32'h44);
        applyStimulus(32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(32'h40, 1'b1, 1'b0, 1'b1, mem_word(32'h40 + 32'(4 * i)));
            nextCycle();
        end
        applyStimulus(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_req", {31'b0, mem_req}, 32'd0);
        checkOutput("post_reset_stall", {31'b0, inst_cache_stall}, 32'd0);
        nextCycle();
        applyStimulus(32'h40, 1'b0, 1'b0, 1'b1, 32'hDEAD);
        nextCycle();
        doMiss(32'h40, 0, -1);
        fetchHit(32'h44, 32'hB1);

        // Stray rvalid in IDLE during a hit, then fetch_en low
        exp_inst.push_back(32'hB1);
        applyStimulus(32'h44, 1'b1, 1'b0, 1'b1, 32'hDEAD);
        nextCycle();
        fetchHit(32'h44, 32'hB1);
        fetchHit(32'h40, 32'hB0);
        applyStimulus(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("no_fetch_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("no_fetch_stall", {31'b0, inst_cache_stall}, 32'd0);
        nextCycle();

`ifdef ICACHE_PERF_CNT_EN
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("miss_cnt_reset", miss_cnt, 32'd0);
        checkOutput("hit_cnt_reset", hit_cnt, 32'd0);
        nextCycle();
        doMiss(32'h0, 0, -1);
        fetchHit(32'h0, 32'hA0);
        fetchHit(32'h4, 32'hA1);
        fetchHit(32'h8, 32'hA2);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("miss_cnt", miss_cnt, 32'd1);
        checkOutput("hit_cnt", hit_cnt, 32'd3);
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("miss_cnt_cleared", miss_cnt, 32'd0);
        checkOutput("hit_cnt_cleared", hit_cnt, 32'd0);
        nextCycle();
`endif

        checkOutput("inst_queue_left", 32'(exp_inst.size()), 32'd0);
        checkOutput("addr_queue_left", 32'(exp_addr.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
